// File: rtl/outer_product_driver_pkg.sv
// Shared constants and FSM state type for the outer-product
// self-test driver.
package outer_product_driver_pkg;

  localparam int N_ELEM      = 16;
  localparam int DATA_W      = 4;
  localparam int PROD_W      = 2 * DATA_W;
  localparam int TIMEOUT_CYC = 5000;
  localparam int LAT_W       = 13;
  localparam int IDX_W       = 8;
  localparam int ERR_W       = 9;
  localparam int K_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    DONE
  } state_t;

endpackage

// File: rtl/outer_product_driver_rf.sv
// Operand register file: A and B banks, one write port,
// burst read port plus row/column check read ports.
module op_operand_rf
  import outer_product_driver_pkg::*;
(
  input  logic              clk1,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [K_W-1:0]    send_idx,
  output logic [DATA_W-1:0] send_a,
  output logic [DATA_W-1:0] send_b,
  input  logic [K_W-1:0]    row,
  input  logic [K_W-1:0]    col,
  output logic [DATA_W-1:0] row_a,
  output logic [DATA_W-1:0] col_b
);

  logic [DATA_W-1:0] mem_a [N_ELEM];
  logic [DATA_W-1:0] mem_b [N_ELEM];

  // Operand storage is deliberately not reset
  always_ff @(posedge clk1) begin
    if (we) begin
      if (waddr[4]) mem_b[waddr[3:0]] <= wdata;
      else          mem_a[waddr[3:0]] <= wdata;
    end
  end

  assign send_a = mem_a[send_idx];
  assign send_b = mem_b[send_idx];
  assign row_a  = mem_a[row];
  assign col_b  = mem_b[col];

endmodule

// File: rtl/outer_product_driver.sv
// Drives a 16-beat operand burst and checks the 256-beat
// outer-product response, reporting errors and latency.
module outer_product_driver
  import outer_product_driver_pkg::*;
(
  input  logic              clk1,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [3:0]        cfg_wdata,
  input  logic              start,
  output logic              in_valid,
  output logic [3:0]        in_matrix_A,
  output logic [3:0]        in_matrix_B,
  input  logic              out_valid,
  input  logic [7:0]        out_matrix,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [8:0]        err_count,
  output logic [7:0]        first_err_idx,
  output logic [LAT_W-1:0]  latency,
  output logic              timeout,
  output logic              proto_err
);

  localparam logic [LAT_W-1:0] TMO = LAT_W'(TIMEOUT_CYC);

  state_t              state;
  logic [K_W-1:0]      k;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   send_a, send_b;
  logic [DATA_W-1:0]   row_a, col_b;
  logic [PROD_W-1:0]   exp_val;
  logic [LAT_W-1:0]    lat_next;
  logic                listening;
  logic                accept;
  logic                beat_err;
  logic                last_beat;
  logic                tmo_hit;

  op_operand_rf u_rf (
    .clk1     (clk1),
    .we       (cfg_we && state == IDLE),
    .waddr    (cfg_addr),
    .wdata    (cfg_wdata),
    .send_idx (k),
    .send_a   (send_a),
    .send_b   (send_b),
    .row      (idx[7:4]),
    .col      (idx[3:0]),
    .row_a    (row_a),
    .col_b    (col_b)
  );

  assign exp_val   = PROD_W'(row_a) * PROD_W'(col_b);
  assign listening = (state == WAIT) || (state == RECV);
  assign accept    = listening && out_valid;
  assign beat_err  = accept && (out_matrix != exp_val);
  assign last_beat = accept && (idx == 8'hFF);
  assign lat_next  = latency + 1'b1;
  assign tmo_hit   = listening && !accept && !last_beat
                     && (lat_next >= TMO);

  assign in_valid    = (state == SEND);
  assign in_matrix_A = in_valid ? send_a : '0;
  assign in_matrix_B = in_valid ? send_b : '0;
  assign busy        = (state == SEND) || listening;

  // Run control FSM with registered result outputs
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      k             <= '0;
      idx           <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      latency       <= '0;
      timeout       <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= SEND;
            k             <= '0;
            idx           <= '0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            latency       <= '0;
            timeout       <= 1'b0;
            proto_err     <= 1'b0;
          end
        end
        SEND: begin
          k <= k + 1'b1;
          if (out_valid) proto_err <= 1'b1;
          if (k == 4'hF) state <= WAIT;
        end
        WAIT, RECV: begin
          latency <= lat_next;
          if (accept) begin
            idx <= idx + 1'b1;
            if (beat_err) begin
              if (err_count != 9'd256)
                err_count <= err_count + 1'b1;
              if (err_count == '0)
                first_err_idx <= idx;
            end
          end
          if (last_beat) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !beat_err
                     && !proto_err && !timeout;
          end else if (tmo_hit) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else if (accept) begin
            state <= RECV;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
